icache_ctrl: RTL and testbench

Direct-mapped instruction cache controller between the instruction fetcher and the memory allocator. Serves hits from local storage in one cycle; on a miss it latches the PC, requests a 4-byte instruction read from the allocator, fills the line and returns the instruction to the fetcher. A branch clear aborts any in-flight miss without corrupting cache contents.

---
 rtl/icache_ctrl_pkg.sv | 26 ++
 rtl/icache_ctrl_if.sv | 28 ++
 rtl/icache_ctrl_array.sv | 43 ++++
 rtl/icache_ctrl.sv | 125 ++++++++++++
 tb/tb_icache_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared configuration for the instruction cache controller: widths,
// boolean/zero constants, FSM state encoding and the lookup result record.
package icache_ctrl_pkg;
  localparam int AddrWidth        = 32;
  localparam int InstrWidth       = 32;
  localparam int ICacheIndexWidth = 6;

  localparam logic                  TRUE  = 1'b1;
  localparam logic                  FALSE = 1'b0;
  localparam logic [InstrWidth-1:0] ZERO  = '0;

  // Every fill is one full 4-byte word: byte count minus one.
  localparam logic [1:0] FETCH_OFFSET = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } ic_state_e;

  // Result of probing the array with the fetch PC.
  typedef struct packed {
    logic                  hit;
    logic [InstrWidth-1:0] data;
  } ic_lookup_t;
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetcher + allocator handshake bundle. master = cache side, slave = the
// environment (fetcher and allocator) side.
interface icache_ctrl_if
  import icache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = AddrWidth
);
  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_pc_in;
  logic                  ic_valid_out;
  logic [InstrWidth-1:0] ic_instr_out;
  logic                  ic_to_alloc_en_out;
  logic [ADDR_WIDTH-1:0] ic_a_out;
  logic [1:0]            ic_offset_out;
  logic                  alloc_to_ic_gr_in;
  logic                  alloc_to_ic_en_in;
  logic [InstrWidth-1:0] alloc_d_in;

  modport master (
    input  if_req_in, if_pc_in, alloc_to_ic_gr_in, alloc_to_ic_en_in, alloc_d_in,
    output ic_valid_out, ic_instr_out, ic_to_alloc_en_out, ic_a_out, ic_offset_out
  );

  modport slave (
    output if_req_in, if_pc_in, alloc_to_ic_gr_in, alloc_to_ic_en_in, alloc_d_in,
    input  ic_valid_out, ic_instr_out, ic_to_alloc_en_out, ic_a_out, ic_offset_out
  );
endinterface

// File: rtl/icache_ctrl_array.sv
// Direct-mapped line storage: one word per line. Combinational read port,
// one synchronous write port. Only the valid bits are reset.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int TAG_WIDTH   = AddrWidth - ICacheIndexWidth - 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [InstrWidth-1:0]  rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [InstrWidth-1:0]  wr_data
);
  localparam int Lines = 1 << INDEX_WIDTH;

  logic [Lines-1:0]                 valid_q;
  logic [Lines-1:0][TAG_WIDTH-1:0]  tag_q;
  logic [Lines-1:0][InstrWidth-1:0] data_q;

  // Valid bits: cleared asynchronously, set when a line is filled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)     valid_q         <= '0;
    else if (wr_en) valid_q[wr_idx] <= TRUE;
  end

  // Tag/data payload: no reset, contents are meaningless until valid.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller. Hits return in one cycle;
// misses latch the PC, request one word from the allocator, fill the line
// and forward the word. A branch clear aborts any miss without writing.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int ADDR_WIDTH  = AddrWidth
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear_branch_in,
  icache_ctrl_if.master bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  ic_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] miss_pc_q, miss_pc_d;
  logic                  valid_q, valid_d;
  logic                  en_q, en_d;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic                  fill;

  logic [INDEX_WIDTH-1:0] pc_idx;
  logic [TAG_WIDTH-1:0]   pc_tag;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [InstrWidth-1:0]  rd_data;
  ic_lookup_t             lkp;

  assign pc_idx = bus.if_pc_in[INDEX_WIDTH+1:2];
  assign pc_tag = bus.if_pc_in[ADDR_WIDTH-1:INDEX_WIDTH+2];

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill & rdy_in),
    .wr_idx   (miss_pc_q[INDEX_WIDTH+1:2]),
    .wr_tag   (miss_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data  (bus.alloc_d_in)
  );

  // Probe result for the PC currently presented by the fetcher.
  always_comb begin
    lkp      = '{hit: FALSE, data: ZERO};
    lkp.hit  = rd_valid && (rd_tag == pc_tag);
    lkp.data = rd_data;
  end

  // Next state and next registered outputs; clear beats everything else.
  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    valid_d   = FALSE;
    en_d      = en_q;
    instr_d   = instr_q;
    fill      = FALSE;
    if (clear_branch_in) begin
      state_d = IDLE;
      en_d    = FALSE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The cycle right after a pulse is never a new request.
          if (bus.if_req_in && !valid_q) begin
            if (lkp.hit) begin
              valid_d = TRUE;
              instr_d = lkp.data;
            end else begin
              miss_pc_d = bus.if_pc_in & ~ADDR_WIDTH'(3);
              en_d      = TRUE;
              state_d   = MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (bus.alloc_to_ic_gr_in) begin
            en_d    = FALSE;
            state_d = MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.alloc_to_ic_en_in) begin
            fill    = TRUE;
            valid_d = TRUE;
            instr_d = bus.alloc_d_in;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      miss_pc_q <= '0;
      valid_q   <= FALSE;
      en_q      <= FALSE;
      instr_q   <= ZERO;
    end else if (rdy_in) begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      valid_q   <= valid_d;
      en_q      <= en_d;
      instr_q   <= instr_d;
    end
  end

  assign bus.ic_valid_out       = valid_q;
  assign bus.ic_instr_out       = instr_q;
  assign bus.ic_to_alloc_en_out = en_q;
  assign bus.ic_a_out           = miss_pc_q;
  assign bus.ic_offset_out      = FETCH_OFFSET;
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed table of fetches, hand-written corner
// sequences (flush, stall, async reset) and a randomized phase checked
// against a resident-line map plus a synthetic memory function.
module tb_icache_ctrl;
  logic clk_in, rst_in, rdy_in, clear_branch_in;
  int   total, bad;

  icache_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  icache_ctrl #(.INDEX_WIDTH(6), .ADDR_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .clear_branch_in (clear_branch_in),
    .bus             (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] fill;
    int          gdly;
    int          stall;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] resident [int];   // line index -> word address held there

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One complete fetch. Misses are served by an allocator that grants
  // after gdly cycles (optionally while rdy_in is held low for 'stall'
  // cycles), transfers for one cycle, then pulses the data word. With
  // 'flush' set, the branch clear coincides with the data pulse.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] fill,
                          input int gdly, input int stall, input bit flush,
                          input bit exp_hit, input logic [31:0] exp_instr);
    logic [31:0] a;
    a = pc & 32'hFFFF_FFFC;
    bus.if_req_in = 1'b1;
    bus.if_pc_in  = pc;
    step();
    if (exp_hit) begin
      chk("hit_valid", bus.ic_valid_out, 1);
      chk("hit_instr", bus.ic_instr_out, exp_instr);
      chk("hit_no_en", bus.ic_to_alloc_en_out, 0);
    end else begin
      chk("miss_en", bus.ic_to_alloc_en_out, 1);
      chk("miss_addr", bus.ic_a_out, a);
      chk("miss_offset", bus.ic_offset_out, 3);
      chk("miss_no_valid", bus.ic_valid_out, 0);
      bus.if_pc_in = pc ^ 32'h0000_0F04;   // PC wanders; miss address must not
      repeat (gdly) step();
      chk("wait_en", bus.ic_to_alloc_en_out, 1);
      if (stall > 0) begin
        bus.alloc_to_ic_gr_in = 1'b1;
        rdy_in = 1'b0;
        repeat (stall) step();
        chk("stall_en", bus.ic_to_alloc_en_out, 1);
        chk("stall_addr", bus.ic_a_out, a);
        rdy_in = 1'b1;
      end
      bus.alloc_to_ic_gr_in = 1'b1;
      step();
      chk("gnt_en_low", bus.ic_to_alloc_en_out, 0);
      step();
      bus.alloc_to_ic_en_in = 1'b1;
      bus.alloc_d_in        = fill;
      clear_branch_in       = flush;
      step();
      bus.alloc_to_ic_en_in = 1'b0;
      bus.alloc_to_ic_gr_in = 1'b0;
      clear_branch_in       = 1'b0;
      if (flush) begin
        chk("flush_no_valid", bus.ic_valid_out, 0);
      end else begin
        chk("fill_valid", bus.ic_valid_out, 1);
        chk("fill_instr", bus.ic_instr_out, exp_instr);
      end
      chk("hold_addr", bus.ic_a_out, a);
    end
    bus.if_req_in = 1'b0;
    step();
    chk("pulse_end", bus.ic_valid_out, 0);
  endtask

  initial begin
    logic [31:0] pc, wa;
    int          idx, st;
    bit          hit, fl;
    total = 0;
    bad   = 0;

    tbl[0] = '{32'h0000_1000, 32'h0130_0093, 2, 0, 1'b0, 32'h0130_0093};
    tbl[1] = '{32'h0000_1000, 32'h0000_0000, 0, 0, 1'b1, 32'h0130_0093};
    tbl[2] = '{32'h0000_1100, 32'h00A0_0113, 0, 0, 1'b0, 32'h00A0_0113};
    tbl[3] = '{32'h0000_1000, 32'h0130_0093, 1, 0, 1'b0, 32'h0130_0093};
    tbl[4] = '{32'h0000_1103, 32'h00A0_0113, 0, 0, 1'b0, 32'h00A0_0113};
    tbl[5] = '{32'h0000_1004, 32'h0020_0193, 3, 0, 1'b0, 32'h0020_0193};
    tbl[6] = '{32'h0000_1102, 32'h0000_0000, 0, 0, 1'b1, 32'h00A0_0113};
    tbl[7] = '{32'h0000_1007, 32'h0000_0000, 0, 0, 1'b1, 32'h0020_0193};
    tbl[8] = '{32'h0000_1000, 32'h0130_0093, 0, 2, 1'b0, 32'h0130_0093};
    tbl[9] = '{32'h0000_1001, 32'h0000_0000, 0, 0, 1'b1, 32'h0130_0093};

    rst_in                = 1'b0;
    rdy_in                = 1'b1;
    clear_branch_in       = 1'b0;
    bus.if_req_in         = 1'b0;
    bus.if_pc_in          = '0;
    bus.alloc_to_ic_gr_in = 1'b0;
    bus.alloc_to_ic_en_in = 1'b0;
    bus.alloc_d_in        = '0;

    // Reset state, before any clock edge.
    #1 rst_in = 1'b1;
    #1;
    chk("rst_valid", bus.ic_valid_out, 0);
    chk("rst_instr", bus.ic_instr_out, 0);
    chk("rst_en", bus.ic_to_alloc_en_out, 0);
    chk("rst_addr", bus.ic_a_out, 0);
    step();
    step();
    rst_in = 1'b0;
    step();

    // Directed table: cold miss, hit, conflict evictions, word aliasing.
    for (int i = 0; i < 10; i++)
      do_fetch(tbl[i].pc, tbl[i].fill, tbl[i].gdly, tbl[i].stall, 1'b0,
               tbl[i].hit, tbl[i].exp);

    // Flush coincident with the data pulse: no pulse, no fill.
    do_fetch(32'h0000_2000, 32'hDEAD_BEEF, 1, 0, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h0000_2000, 32'h0050_0213, 0, 0, 1'b0, 1'b0, 32'h0050_0213);
    do_fetch(32'h0000_2000, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0050_0213);

    // Three-cycle stall in MISS_REQ with grant already up.
    do_fetch(32'h0000_3000, 32'h0070_0293, 0, 3, 1'b0, 1'b0, 32'h0070_0293);

    // Clear in IDLE beats a hitting request.
    bus.if_req_in   = 1'b1;
    bus.if_pc_in    = 32'h0000_3000;
    clear_branch_in = 1'b1;
    step();
    chk("clr_idle_valid", bus.ic_valid_out, 0);
    clear_branch_in = 1'b0;
    step();
    chk("after_clr_hit", bus.ic_valid_out, 1);
    chk("after_clr_instr", bus.ic_instr_out, 32'h0070_0293);
    // Pulse stretches while rdy_in is low.
    rdy_in        = 1'b0;
    bus.if_req_in = 1'b0;
    step();
    step();
    chk("stall_hold_valid", bus.ic_valid_out, 1);
    chk("stall_hold_instr", bus.ic_instr_out, 32'h0070_0293);
    rdy_in = 1'b1;
    step();
    chk("stall_pulse_end", bus.ic_valid_out, 0);

    // Async reset in MISS_WAIT after 0x1000 was filled.
    do_fetch(32'h0000_1000, 32'h0130_0093, 0, 0, 1'b0, 1'b0, 32'h0130_0093);
    bus.if_req_in = 1'b1;
    bus.if_pc_in  = 32'h0000_1040;
    step();
    chk("pre_rst_en", bus.ic_to_alloc_en_out, 1);
    bus.alloc_to_ic_gr_in = 1'b1;
    step();
    bus.alloc_to_ic_gr_in = 1'b0;
    bus.if_req_in         = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("arst_addr", bus.ic_a_out, 0);
    chk("arst_instr", bus.ic_instr_out, 0);
    chk("arst_en", bus.ic_to_alloc_en_out, 0);
    chk("arst_valid", bus.ic_valid_out, 0);
    step();
    rst_in = 1'b0;
    step();
    do_fetch(32'h0000_1000, 32'h0130_0093, 0, 0, 1'b0, 1'b0, 32'h0130_0093);

    // Randomized phase from a clean cache.
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    resident.delete();
    for (int n = 0; n < 150; n++) begin
      pc  = ($urandom_range(0, 1) << 30) | ($urandom_range(0, 3) << 8) |
            ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      wa  = pc & 32'hFFFF_FFFC;
      idx = int'(pc[7:2]);
      hit = resident.exists(idx) && (resident[idx] == wa);
      fl  = !hit && ($urandom_range(0, 5) == 0);
      st  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_fetch(pc, mem_word(wa), int'($urandom_range(0, 3)), st, fl, hit, mem_word(wa));
      if (!hit && !fl) resident[idx] = wa;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
